// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the slow-clock frequency meter: FSM encoding and
// default measurement constants derived from the 50 MHz system clock.
package clk_freq_meter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meas_state_e;

  localparam int unsigned SYS_CLK_HZ       = 50_000_000;
  localparam int unsigned DEF_CNT_W        = 24;
  localparam int unsigned DEF_EXP_PERIOD   = SYS_CLK_HZ / 500;
  localparam int unsigned DEF_TOL          = 100;
  localparam int unsigned DEF_TIMEOUT      = SYS_CLK_HZ / 5;
  localparam int unsigned DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Synchronizer chain plus one-flop edge detector for an asynchronous input.
// Edges are suppressed until the chain holds only post-reset samples.
module sync_edge_det
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise_p,
  output logic fall_p
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: SYNC_STAGES must be at least 2");
  end

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   primed;
  logic                   level;

  // A level held high through reset must not look like a rising edge, so
  // wait until the previous-sample flop carries a real post-reset value.
  assign primed = (fill_q == FILL_DONE);
  assign level  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= level;
      if (!primed) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign rise_p = primed &  level & ~prev_q;
  assign fall_p = primed & ~level &  prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Period / high-time meter for a slow input, counted in clk_in cycles, with
// an expected-period range check and a stalled-input timeout.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             in_range,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [CNT_W:0] EXP_S  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S  = (CNT_W+1)'(TOL);

  logic rise_p;
  logic fall_p;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             in_range_q, in_range_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0]    cnt_inc;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] diff_abs;
  logic                inc_in_tol;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .rise_p (rise_p),
    .fall_p (fall_p)
  );

  // cnt saturates at TIMEOUT, so the one-bit-wider signed difference never wraps.
  always_comb begin
    cnt_inc    = cnt_q + 1'b1;
    diff       = signed'({1'b0, cnt_inc}) - EXP_S;
    diff_abs   = diff[CNT_W] ? -diff : diff;
    inc_in_tol = (diff_abs <= TOL_S);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        hi_d  = '0;
        if (rise_p) begin
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
        if (fall_p) begin
          hi_d = cnt_inc;
        end
        // A rise on the timeout cycle still closes the period normally.
        if (rise_p) begin
          period_d   = cnt_inc;
          high_d     = hi_q;
          in_range_d = inc_in_tol;
          valid_d    = 1'b1;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          hi_d       = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d  = 1'b1;
          in_range_d = 1'b0;
          state_d    = ST_IDLE;
          cnt_d      = '0;
          hi_d       = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign valid      = valid_q;
  assign in_range   = in_range_q;
  assign timeout    = timeout_q;

endmodule
